multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Sequencing controller for the multicycle MIPS datapath, where one shared memory, one ALU and the IR/A/B/ALUOut registers are reused across cycles. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback states, driving the mux selects and write strobes each cycle. It supports R-type (add/sub/and/or/slt), LW, SW, BEQ, ADDI and J. Memory accesses wait on a ready handshake.

Parameters:
None. Encodings are fixed in the shared package.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pcen  out  1  PC write enable = pcwrite | (branch & zero)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
irwrite  out  1  IR load
memwrite  out  1  memory write strobe
regwrite  out  1  register file write
regdst  out  1  write register select: 1 = rd, 0 = rt
memtoreg  out  1  writeback select: 1 = data register, 0 = ALUOut
alusrca  out  1  ALU A select: 0 = PC, 1 = A
alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  out  2  next PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal  out  1  one-cycle pulse on an unsupported op or funct

Behaviour:
- Synchronous reset.
  - State goes to FETCH on the next edge.
  - While reset is high, pcen, irwrite, memwrite and regwrite are forced 0.
- All outputs are decoded from the current state only. Every signal not listed for a state is 0; no output is ever x.
- FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite and pcwrite are asserted only when mem_ready=1; the state advances to DECODE only then.
  - Otherwise the FSM stays in FETCH and the PC does not advance.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - LW or SW -> MEMADR
  - R-type -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other op -> FETCH with illegal=1 for that cycle
- MEMADR: alusrca=1, alusrcb=10, add. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1, held while waiting. Goes to FETCH on mem_ready=1; memwrite drops the next cycle.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Supported funct -> ALUWB.
  - Unsupported funct -> FETCH with illegal=1, alucontrol=add, and no register write.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1, so pcen=zero. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state FETCH.
- Latency in cycles with mem_ready held at 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every other state.
- A reset mid-instruction abandons the instruction; no writeback or memwrite occurs after the reset edge.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010)
  - funct constants
  - alucontrol encodings
  - the state enum (12 states)
- Sub-module alu_decoder: combinational mapping of a 2-bit aluop (00 add, 01 sub, 10 funct) plus funct to alucontrol and a funct_valid flag.
- The FSM instantiates alu_decoder and derives illegal from funct_valid in EXECUTE.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and op=R-type, funct=100000 -> FETCH, DECODE, EXECUTE, ALUWB. regwrite=1 and regdst=1 in cycle 4; pcen=1 only in cycle 1; alucontrol=010 in EXECUTE.
- LW with mem_ready low for 3 cycles in MEMRD -> iord=1 held for 4 cycles. MEMWB follows with memtoreg=1 and regwrite=1; 8 cycles total.
- SW, mem_ready=1 -> memwrite=1 for exactly one cycle in cycle 4; regwrite stays 0 throughout.
- BEQ with zero=1 -> pcen=1 and pcsrc=01 in cycle 3. Repeated with zero=0 -> pcen=0 in cycle 3.
- op=111111 -> illegal pulses in DECODE, then FETCH. Separately, R-type with funct=000111 -> illegal pulses in EXECUTE and no regwrite follows.
- reset asserted during MEMWR and during ALUWB -> memwrite and regwrite are 0 from the reset edge on, and the next instruction starts in FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU control values and the controller state set.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU control decode: fixed add/sub, or R-type funct lookup with a validity flag.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    always_comb begin
        alucontrol  = ALU_ADD;
        funct_valid = 1'b1;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    // unknown funct falls back to add so no stray op is issued
                    default:   funct_valid = 1'b0;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing FSM for the multicycle MIPS datapath; memory states stall
// on mem_ready, and reset masks all write strobes while asserted.
module multicycle_control_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t     state, state_n;
    aluop_t     aluop;
    logic [2:0] dec_alucontrol;
    logic       funct_valid;
    logic       use_alu;
    logic       pcwrite, branch, irw, memw, regw;

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .alucontrol  (dec_alucontrol),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Kept apart from the main decode so funct_valid never loops back into aluop.
    always_comb begin
        case (state)
            S_BRANCH:  aluop = ALUOP_SUB;
            S_EXECUTE: aluop = ALUOP_FUNCT;
            default:   aluop = ALUOP_ADD;
        endcase
    end

    always_comb begin
        state_n  = state;
        use_alu  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irw      = 1'b0;
        memw     = 1'b0;
        regw     = 1'b0;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                use_alu = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irw     = 1'b1;
                    pcwrite = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                use_alu = 1'b1;
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXECUTE;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_n = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                use_alu = 1'b1;
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW)      state_n = S_MEMRD;
                else if (op == OP_SW) state_n = S_MEMWR;
                else                  state_n = S_FETCH;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regw     = 1'b1;
                state_n  = S_FETCH;
            end
            S_MEMWR: begin
                iord = 1'b1;
                memw = 1'b1;
                if (mem_ready) state_n = S_FETCH;
            end
            S_EXECUTE: begin
                use_alu = 1'b1;
                alusrca = 1'b1;
                if (funct_valid) begin
                    state_n = S_ALUWB;
                end else begin
                    illegal = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_ALUWB: begin
                regdst  = 1'b1;
                regw    = 1'b1;
                state_n = S_FETCH;
            end
            S_BRANCH: begin
                use_alu = 1'b1;
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_n = S_FETCH;
            end
            S_ADDIEX: begin
                use_alu = 1'b1;
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = S_ADDIWB;
            end
            S_ADDIWB: begin
                regw    = 1'b1;
                state_n = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    assign alucontrol = use_alu ? dec_alucontrol : '0;
    assign pcen       = ~reset & (pcwrite | (branch & zero));
    assign irwrite    = ~reset & irw;
    assign memwrite   = ~reset & memw;
    assign regwrite   = ~reset & regw;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: instruction-level reference plans push per-cycle expected outputs,
// a negedge monitor pops and compares against the controller.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic       rdy;
        logic       z;
        logic [5:0] op;
        logic [5:0] funct;
        outs_t      exp;
    } cyc_t;

    outs_t expq[$];
    string tname = "reset";
    int    checks = 0;
    int    errors = 0;
    int    cycno  = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit funct_ok(input logic [5:0] f, output logic [2:0] c);
        c = 3'b010;
        case (f)
            6'b100000: c = 3'b010;
            6'b100010: c = 3'b110;
            6'b100100: c = 3'b000;
            6'b100101: c = 3'b001;
            6'b101010: c = 3'b111;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // per-cycle expected outputs, taken straight from the state descriptions
    function automatic outs_t o_fetch(input logic r);
        outs_t o = '0;
        o.alusrcb = 2'b01; o.alucontrol = 3'b010; o.irwrite = r; o.pcen = r;
        return o;
    endfunction
    function automatic outs_t o_decode(input logic ill);
        outs_t o = '0;
        o.alusrcb = 2'b11; o.alucontrol = 3'b010; o.illegal = ill;
        return o;
    endfunction
    function automatic outs_t o_memadr();
        outs_t o = '0;
        o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010;
        return o;
    endfunction
    function automatic outs_t o_exec(input logic [5:0] f);
        outs_t o = '0;
        logic [2:0] c;
        o.alusrca = 1'b1;
        o.illegal = !funct_ok(f, c);
        o.alucontrol = c;
        return o;
    endfunction
    function automatic outs_t o_branch(input logic z);
        outs_t o = '0;
        o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z;
        return o;
    endfunction
    function automatic outs_t o_simple(input int kind);
        outs_t o = '0;
        case (kind)
            0: o.iord = 1'b1;                                          // memory read
            1: begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end         // load writeback
            2: begin o.iord = 1'b1; o.memwrite = 1'b1; end             // memory write
            3: begin o.regdst = 1'b1; o.regwrite = 1'b1; end           // R writeback
            4: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
            5: o.regwrite = 1'b1;                                      // addi writeback
            default: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end         // jump
        endcase
        return o;
    endfunction
    function automatic outs_t strip(input outs_t o);
        outs_t s = o;
        s.pcen = 1'b0; s.irwrite = 1'b0; s.memwrite = 1'b0; s.regwrite = 1'b0;
        return s;
    endfunction

    function automatic outs_t actual();
        outs_t a;
        a = {pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
             alusrcb, pcsrc, alucontrol, illegal};
        return a;
    endfunction

    initial begin
        outs_t e, a;
        forever begin
            @(negedge clk);
            cycno++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = actual();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cycle %0d outs actual=%b required=%b", tname, cycno, a, e);
                end
            end
        end
    end

    task automatic drive(input logic rst, input cyc_t c);
        @(posedge clk);
        #1;
        reset = rst; mem_ready = c.rdy; zero = c.z; op = c.op; funct = c.funct;
        expq.push_back(rst ? strip(c.exp) : c.exp);
    endtask

    // Build the whole cycle-by-cycle plan of one instruction, then play it.
    // fw: fetch stall cycles; mw: memory stall cycles (<0 random); zf: branch zero (<0 random);
    // abort_at: plan index at which reset is asserted (<0 none).
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                             input int fw, input int mw, input int zf, input int abort_at);
        cyc_t plan[$];
        cyc_t c;
        int   nmw;
        c.op = iop; c.funct = ifn;
        nmw = (mw < 0) ? int'($urandom_range(0, 3)) : mw;
        for (int i = 0; i < fw; i++) begin
            c.rdy = 1'b0; c.z = rb(); c.exp = o_fetch(1'b0); plan.push_back(c);
        end
        c.rdy = 1'b1; c.z = rb(); c.exp = o_fetch(1'b1); plan.push_back(c);
        c.rdy = rb(); c.z = rb();
        case (iop)
            6'b100011, 6'b101011: begin
                c.exp = o_decode(1'b0); plan.push_back(c);
                c.rdy = rb(); c.z = rb(); c.exp = o_memadr(); plan.push_back(c);
                for (int i = 0; i <= nmw; i++) begin
                    c.rdy = (i == nmw); c.z = rb();
                    c.exp = o_simple(iop == 6'b100011 ? 0 : 2);
                    plan.push_back(c);
                end
                if (iop == 6'b100011) begin
                    c.rdy = rb(); c.z = rb(); c.exp = o_simple(1); plan.push_back(c);
                end
            end
            6'b000000: begin
                logic [2:0] dummy;
                c.exp = o_decode(1'b0); plan.push_back(c);
                c.rdy = rb(); c.z = rb(); c.exp = o_exec(ifn); plan.push_back(c);
                if (funct_ok(ifn, dummy)) begin
                    c.rdy = rb(); c.z = rb(); c.exp = o_simple(3); plan.push_back(c);
                end
            end
            6'b000100: begin
                c.exp = o_decode(1'b0); plan.push_back(c);
                c.rdy = rb(); c.z = (zf < 0) ? rb() : zf[0];
                c.exp = o_branch(c.z); plan.push_back(c);
            end
            6'b001000: begin
                c.exp = o_decode(1'b0); plan.push_back(c);
                c.rdy = rb(); c.z = rb(); c.exp = o_simple(4); plan.push_back(c);
                c.rdy = rb(); c.z = rb(); c.exp = o_simple(5); plan.push_back(c);
            end
            6'b000010: begin
                c.exp = o_decode(1'b0); plan.push_back(c);
                c.rdy = rb(); c.z = rb(); c.exp = o_simple(6); plan.push_back(c);
            end
            default: begin
                c.exp = o_decode(1'b1); plan.push_back(c);
            end
        endcase
        foreach (plan[i]) begin
            if (i == abort_at) begin
                drive(1'b1, plan[i]);
                c.rdy = rb(); c.z = rb(); c.exp = o_fetch(c.rdy);
                drive(1'b1, c);
                return;
            end
            drive(1'b0, plan[i]);
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [6];
        cyc_t       c;
        logic [5:0] rop, rfn;
        int         ab;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b010001};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;

        // two reset cycles in FETCH with mem_ready high: strobes must stay masked
        c.rdy = 1'b1; c.z = 1'b1; c.op = 6'b000000; c.funct = 6'b100000; c.exp = o_fetch(1'b1);
        drive(1'b1, c);
        drive(1'b1, c);

        tname = "radd";       run_instr(6'b000000, 6'b100000, 0, 0, -1, -1);
        tname = "lw_stall";   run_instr(6'b100011, 6'b000000, 0, 3, -1, -1);
        tname = "sw";         run_instr(6'b101011, 6'b000000, 0, 0, -1, -1);
        tname = "beq_z1";     run_instr(6'b000100, 6'b000000, 0, 0, 1, -1);
        tname = "beq_z0";     run_instr(6'b000100, 6'b000000, 0, 0, 0, -1);
        tname = "addi";       run_instr(6'b001000, 6'b000000, 1, 0, -1, -1);
        tname = "jump";       run_instr(6'b000010, 6'b000000, 2, 0, -1, -1);
        tname = "bad_op";     run_instr(6'b111111, 6'b100000, 0, 0, -1, -1);
        tname = "bad_funct";  run_instr(6'b000000, 6'b000111, 0, 0, -1, -1);
        tname = "rst_memwr";  run_instr(6'b101011, 6'b000000, 0, 2, -1, 4);
        tname = "rst_aluwb";  run_instr(6'b000000, 6'b100010, 0, 0, -1, 3);
        tname = "after_rst";  run_instr(6'b000010, 6'b000000, 0, 0, -1, -1);

        tname = "random";
        for (int n = 0; n < 300; n++) begin
            rop = ops[$urandom_range(0, 7)];
            rfn = fns[$urandom_range(0, 5)];
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(rop, rfn, int'($urandom_range(0, 2)), -1, -1, ab);
        end

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
